// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//   Shares the single write port of a 32x32 register file between core
//   writeback (priority requester) and a debug/external-load requester that
//   uses a valid/ready handshake. A starvation counter forces a debug grant
//   after MAX_WAIT consecutive lost cycles, stalling the core for that cycle.
//
//   Optional feature macro: REGFILE_ARB_INIT_SWEEP_EN
//     defined   -> after reset a 31-cycle sweep writes x1..x31 (x2 = SP_INIT,
//                  others 0) before normal operation.
//     undefined -> no sweep; reset goes straight to RUN, init_busy_o = 0.
//
//   Ports:
//     clk, reset            clock, synchronous active-high reset
//     core_we_i/rd_i/data_i core writeback request (x0 = no request)
//     dbg_valid_i/rd_i/data_i, dbg_ready_o   debug write handshake
//     stall_o               core must hold its current instruction
//     init_busy_o           init sweep in progress
//     Reg_Write_o, Write_Register_o, Write_Data_o   register file write port
//
//   All outputs are combinational from registered state and current inputs,
//   so a granted write reaches the register file in the same cycle.
module regfile_write_arbiter #(
  parameter int             N        = 32,
  parameter int             MAX_WAIT = 8,
  parameter logic [N-1:0]   SP_INIT  = 32'h00000FFF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         core_we_i,
  input  logic [4:0]   core_rd_i,
  input  logic [N-1:0] core_data_i,
  input  logic         dbg_valid_i,
  input  logic [4:0]   dbg_rd_i,
  input  logic [N-1:0] dbg_data_i,
  output logic         dbg_ready_o,
  output logic         stall_o,
  output logic         init_busy_o,
  output logic         Reg_Write_o,
  output logic [4:0]   Write_Register_o,
  output logic [N-1:0] Write_Data_o
);

  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FORCE = 2'd2;
`ifdef REGFILE_ARB_INIT_SWEEP_EN
  localparam logic [1:0] ST_INIT  = 2'd0;
  localparam logic [1:0] ST_RESET = ST_INIT;
`else
  localparam logic [1:0] ST_RESET = ST_RUN;
`endif
  localparam logic [7:0] WAIT_MAX = 8'(MAX_WAIT);

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic [7:0] wait_cnt;
  logic [7:0] wait_nxt;
  logic       core_req;

`ifdef REGFILE_ARB_INIT_SWEEP_EN
  logic [4:0] idx;
  logic [4:0] idx_nxt;
`else
  // SP_INIT only feeds the sweep; keep it referenced in the sweep-less build.
  logic       unused_sp_init;
  assign unused_sp_init = ^SP_INIT;
`endif

  // A core write to x0 is architecturally a no-op, so it does not compete.
  assign core_req = core_we_i && (core_rd_i != 5'd0);

  always_comb begin
    dbg_ready_o      = 1'b0;
    stall_o          = 1'b0;
    init_busy_o      = 1'b0;
    Reg_Write_o      = 1'b0;
    Write_Register_o = 5'd0;
    Write_Data_o     = '0;
    state_nxt        = state;
    wait_nxt         = wait_cnt;
`ifdef REGFILE_ARB_INIT_SWEEP_EN
    idx_nxt          = idx;
`endif
    // Outputs stay quiet while reset is held, whatever the stored state.
    if (!reset) begin
      case (state)
        ST_RUN: begin
          if (core_req) begin
            Reg_Write_o      = 1'b1;
            Write_Register_o = core_rd_i;
            Write_Data_o     = core_data_i;
            if (dbg_valid_i) begin
              // Lost arbitration: escalate to a forced grant when the count
              // would reach the limit; the counter saturates there.
              if (({1'b0, wait_cnt} + 9'd1) >= {1'b0, WAIT_MAX}) begin
                wait_nxt  = WAIT_MAX;
                state_nxt = ST_FORCE;
              end else begin
                wait_nxt = wait_cnt + 8'd1;
              end
            end else begin
              wait_nxt = 8'd0;
            end
          end else begin
            dbg_ready_o = 1'b1;
            wait_nxt    = 8'd0;
            if (dbg_valid_i) begin
              Reg_Write_o      = (dbg_rd_i != 5'd0);
              Write_Register_o = dbg_rd_i;
              Write_Data_o     = dbg_data_i;
            end
          end
        end
        ST_FORCE: begin
          // Debug owns the port; the stalled core re-presents its write later.
          stall_o     = 1'b1;
          dbg_ready_o = 1'b1;
          if (dbg_valid_i) begin
            Reg_Write_o      = (dbg_rd_i != 5'd0);
            Write_Register_o = dbg_rd_i;
            Write_Data_o     = dbg_data_i;
          end
          // Either the handshake completes or valid was dropped: back to RUN.
          state_nxt = ST_RUN;
          wait_nxt  = 8'd0;
        end
`ifdef REGFILE_ARB_INIT_SWEEP_EN
        ST_INIT: begin
          stall_o          = 1'b1;
          init_busy_o      = 1'b1;
          Reg_Write_o      = 1'b1;
          Write_Register_o = idx;
          Write_Data_o     = (idx == 5'd2) ? SP_INIT : '0;
          idx_nxt          = idx + 5'd1;
          if (idx == 5'd31) begin
            state_nxt = ST_RUN;
          end
        end
`endif
        default: begin
          state_nxt = ST_RESET;
          wait_nxt  = 8'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_RESET;
      wait_cnt <= 8'd0;
`ifdef REGFILE_ARB_INIT_SWEEP_EN
      idx      <= 5'd1;
`endif
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
`ifdef REGFILE_ARB_INIT_SWEEP_EN
      idx      <= idx_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter
//   Scoreboard bench: the stimulus process drives one cycle of inputs, asks a
//   behavioural model for the expected outputs of that cycle and queues them;
//   an independent monitor pops and compares each cycle's outputs.
//   Works with REGFILE_ARB_INIT_SWEEP_EN defined or undefined.
module tb_regfile_write_arbiter;

  localparam int          N        = 32;
  localparam int          MAX_WAIT = 8;
  localparam logic [31:0] SP_INIT  = 32'h00000FFF;
`ifdef REGFILE_ARB_INIT_SWEEP_EN
  localparam bit SWEEP = 1'b1;
`else
  localparam bit SWEEP = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         core_we_i = 1'b0;
  logic [4:0]   core_rd_i = '0;
  logic [N-1:0] core_data_i = '0;
  logic         dbg_valid_i = 1'b0;
  logic [4:0]   dbg_rd_i = '0;
  logic [N-1:0] dbg_data_i = '0;
  logic         dbg_ready_o;
  logic         stall_o;
  logic         init_busy_o;
  logic         Reg_Write_o;
  logic [4:0]   Write_Register_o;
  logic [N-1:0] Write_Data_o;

  always #5 clk = ~clk;

  regfile_write_arbiter #(.N(N), .MAX_WAIT(MAX_WAIT), .SP_INIT(SP_INIT)) dut (
    .clk(clk), .reset(reset),
    .core_we_i(core_we_i), .core_rd_i(core_rd_i), .core_data_i(core_data_i),
    .dbg_valid_i(dbg_valid_i), .dbg_rd_i(dbg_rd_i), .dbg_data_i(dbg_data_i),
    .dbg_ready_o(dbg_ready_o), .stall_o(stall_o), .init_busy_o(init_busy_o),
    .Reg_Write_o(Reg_Write_o), .Write_Register_o(Write_Register_o),
    .Write_Data_o(Write_Data_o)
  );

  typedef struct packed {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        rdy;
    logic        stall;
    logic        busy;
  } out_t;

  out_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Model state: how many consecutive cycles debug has been refused, whether
  // the next cycle is a forced debug grant, and the next sweep address (0 = none).
  int lost   = 0;
  bit forced = 1'b0;
  int sweep  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
  endtask

  task automatic drive(input bit r, input bit cwe, input logic [4:0] crd, input logic [31:0] cd,
                       input bit dv, input logic [4:0] drd, input logic [31:0] dd, output bit acc);
    out_t e;
    @(negedge clk);
    #1;
    reset = r; core_we_i = cwe; core_rd_i = crd; core_data_i = cd;
    dbg_valid_i = dv; dbg_rd_i = drd; dbg_data_i = dd;
    e = '0;
    if (r) begin
      lost = 0; forced = 1'b0; sweep = SWEEP ? 1 : 0;
    end else if (sweep != 0) begin
      e.we = 1'b1; e.addr = 5'(sweep); e.data = (sweep == 2) ? SP_INIT : 32'd0;
      e.stall = 1'b1; e.busy = 1'b1;
      sweep = (sweep == 31) ? 0 : sweep + 1;
    end else if (forced) begin
      e.stall = 1'b1; e.rdy = 1'b1;
      if (dv) begin e.we = (drd != 0); e.addr = drd; e.data = dd; end
      forced = 1'b0; lost = 0;
    end else if (cwe && crd != 0) begin
      e.we = 1'b1; e.addr = crd; e.data = cd;
      if (dv) begin
        lost++;
        if (lost >= MAX_WAIT) forced = 1'b1;
      end else lost = 0;
    end else begin
      e.rdy = 1'b1;
      if (dv) begin e.we = (drd != 0); e.addr = drd; e.data = dd; end
      lost = 0;
    end
    acc = dv && e.rdy;
    exp_q.push_back(e);
  endtask

  // Monitor: compares every presented cycle against the queued expectation.
  initial begin
    out_t e;
    forever begin
      @(negedge clk);
      #3;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("reg_write", 32'(Reg_Write_o), 32'(e.we));
        check("dbg_ready", 32'(dbg_ready_o), 32'(e.rdy));
        check("stall", 32'(stall_o), 32'(e.stall));
        check("init_busy", 32'(init_busy_o), 32'(e.busy));
        if (e.we) begin
          check("write_reg", 32'(Write_Register_o), 32'(e.addr));
          check("write_data", Write_Data_o, e.data);
        end
        if (!e.we && !e.rdy && !e.stall) begin
          // Quiet cycles (reset) must also present a zero address/data.
          check("quiet_addr", 32'(Write_Register_o), 32'd0);
        end
      end
    end
  end

  initial begin
    bit          acc;
    bit          pend;
    logic [4:0]  prd;
    logic [31:0] pdata;
    int          budget;

    // Reset held with active requests on both sides: all outputs zero.
    repeat (3) drive(1, 1, 5'd3, 32'h1, 1, 5'd4, 32'h2, acc);

    if (SWEEP) begin
      // Interrupt the sweep at idx 10, then let it run to completion.
      for (int i = 0; i < 9; i++) drive(0, 1, 5'd6, $urandom, 1, 5'd8, 32'h3, acc);
      drive(1, 1, 5'd6, 32'h5, 1, 5'd8, 32'h3, acc);
      for (int i = 0; i < 31; i++)
        drive(0, 1'($urandom), 5'($urandom), $urandom, 1'($urandom), 5'($urandom), $urandom, acc);
    end

    // First RUN cycle: immediate core writes.
    drive(0, 1, 5'd4, 32'h1, 0, 5'd0, 32'h0, acc);
    drive(0, 1, 5'd5, 32'hA5A5A5A5, 0, 5'd0, 32'h0, acc);

    // Starvation: core writes x7 every cycle, debug waits on x9.
    pend = 1'b1;
    for (int i = 0; i < 12; i++) begin
      drive(0, 1, 5'd7, 32'hC0DE0007, pend, 5'd9, 32'h12345678, acc);
      if (acc) pend = 1'b0;
    end

    // Core targeting x0 does not compete; debug to x0 handshakes without write.
    drive(0, 1, 5'd0, 32'hDEADBEEF, 1, 5'd3, 32'h33333333, acc);
    drive(0, 0, 5'd0, 32'h0, 1, 5'd0, 32'h44444444, acc);

    // Reset asserted in the forced cycle; request is not acknowledged.
    for (int i = 0; i < MAX_WAIT; i++) drive(0, 1, 5'd7, 32'h7, 1, 5'd9, 32'h99, acc);
    drive(1, 1, 5'd7, 32'h7, 1, 5'd9, 32'h99, acc);
    drive(0, 1, 5'd7, 32'h7, 1, 5'd9, 32'h99, acc);
    drive(0, 1, 5'd7, 32'h7, 0, 5'd9, 32'h99, acc);
    if (SWEEP) for (int i = 0; i < 31; i++) drive(0, 1, 5'd7, 32'h7, 0, 5'd0, 32'h0, acc);

    // Protocol violation: valid dropped in the forced cycle.
    for (int i = 0; i < MAX_WAIT; i++) drive(0, 1, 5'd11, 32'hB, 1, 5'd12, 32'hC, acc);
    drive(0, 1, 5'd11, 32'hB, 0, 5'd12, 32'hC, acc);
    drive(0, 1, 5'd11, 32'hB, 1, 5'd12, 32'hC, acc);

    // Randomized traffic with a well-behaved debug requester and rare resets.
    pend = 1'b0; prd = '0; pdata = '0;
    for (int i = 0; i < 1500; i++) begin
      bit r, cwe, dv;
      r = ($urandom_range(299) == 0);
      if (!pend && $urandom_range(99) < 40) begin
        pend = 1'b1; prd = 5'($urandom); pdata = $urandom;
      end
      dv = pend;
      if (pend && $urandom_range(99) < 3) begin dv = 1'b0; pend = 1'b0; end
      cwe = ($urandom_range(99) < ((i < 750) ? 70 : 92));
      drive(r, cwe, 5'($urandom), $urandom, dv, prd, pdata, acc);
      if (acc || r) pend = 1'b0;
    end
    drive(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, acc);

    budget = 0;
    while (exp_q.size() > 0 && budget < 10) begin
      @(negedge clk);
      budget++;
    end
    @(negedge clk);
    #5;
    if (exp_q.size() > 0) begin
      n_checks++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
